// File: rtl/bus_arbiter_decoder.sv
// Two-master serial bus arbiter with 2-bit slave address decode and a combinational data mux.
// Optional split transactions are compiled in when the SPLIT_EN macro is defined.
module bus_arbiter_decoder #(
   parameter int FRAME_LEN = 10,
   parameter int TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       m1_tx,
   input  logic       m2_tx,
   output logic       m1_rx,
   output logic       m2_rx,
   input  logic       s1_tx,
   input  logic       s2_tx,
   input  logic       s3_tx,
   output logic       s1_rx,
   output logic       s2_rx,
   output logic       s3_rx,
   output logic       m1,
   output logic       m2,
   output logic [1:0] addr,
   output logic       addr_rdy,
   output logic       slv_ready,
   output logic       slv_responded
);

   localparam int CW = $clog2((FRAME_LEN > TIMEOUT ? FRAME_LEN : TIMEOUT) + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_SELECT,
      S_WAIT_RDY,
      S_DATA,
      S_RESP
   } state_t;

   state_t          r_state;
   logic            r_m1, r_m2;
   logic            r_pend_m1, r_pend_m2;
   logic [1:0]      r_addr;
   logic            r_addr_msb;
   logic            r_addr_rdy;
   logic            r_slv_ready;
   logic            r_slv_resp;
   logic            r_strobe;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_sig_cnt;   // remaining low cycles of ACK/NACK/SPLIT
   logic            r_sig_m;     // 0 = master1, 1 = master2
`ifdef SPLIT_EN
   logic            r_split_vld;
   logic            r_split_m;
   logic [1:0]      r_split_addr;
   logic            w_split_tx;
`endif

   logic [3:1]      w_s_tx;
   logic [3:1]      w_s_rx;
   logic            w_sel_tx;
   logic            w_gnt_tx;
   logic            w_bad_addr;

   function automatic logic pick_tx(input logic [3:1] tx, input logic [1:0] a);
      case (a)
         2'd1:    return tx[1];
         2'd2:    return tx[2];
         2'd3:    return tx[3];
         default: return 1'b1;
      endcase
   endfunction

   assign w_s_tx   = {s3_tx, s2_tx, s1_tx};
   assign w_sel_tx = pick_tx(w_s_tx, r_addr);
   assign w_gnt_tx = r_m1 ? m1_tx : (r_m2 ? m2_tx : 1'b1);

`ifdef SPLIT_EN
   assign w_split_tx = pick_tx(w_s_tx, r_split_addr);
   assign w_bad_addr = (r_addr == 2'b00) || (r_split_vld && (r_addr == r_split_addr));
`else
   assign w_bad_addr = (r_addr == 2'b00);
`endif

   genvar gi;
   generate
      for (gi = 1; gi <= 3; gi++) begin : g_srx
         assign w_s_rx[gi] = (r_strobe && r_addr == 2'(gi)) ? 1'b0 :
                             (r_state == S_DATA && r_addr == 2'(gi)) ? w_gnt_tx : 1'b1;
      end
   endgenerate

   assign s1_rx = w_s_rx[1];
   assign s2_rx = w_s_rx[2];
   assign s3_rx = w_s_rx[3];

   // Handshake signalling overrides the data mux (ACK overlaps the first data cycle).
   assign m1_rx = ~((r_sig_cnt != 2'd0) && !r_sig_m) &
                  ((r_state == S_DATA && r_m1) ? w_sel_tx : 1'b1);
   assign m2_rx = ~((r_sig_cnt != 2'd0) && r_sig_m) &
                  ((r_state == S_DATA && r_m2) ? w_sel_tx : 1'b1);

   assign m1            = r_m1;
   assign m2            = r_m2;
   assign addr          = r_addr;
   assign addr_rdy      = r_addr_rdy;
   assign slv_ready     = r_slv_ready;
   assign slv_responded = r_slv_resp;

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state      <= S_IDLE;
         r_m1         <= 1'b0;
         r_m2         <= 1'b0;
         r_pend_m1    <= 1'b0;
         r_pend_m2    <= 1'b0;
         r_addr       <= 2'b00;
         r_addr_msb   <= 1'b0;
         r_addr_rdy   <= 1'b0;
         r_slv_ready  <= 1'b0;
         r_slv_resp   <= 1'b0;
         r_strobe     <= 1'b0;
         r_cnt        <= '0;
         r_sig_cnt    <= 2'd0;
         r_sig_m      <= 1'b0;
`ifdef SPLIT_EN
         r_split_vld  <= 1'b0;
         r_split_m    <= 1'b0;
         r_split_addr <= 2'b00;
`endif
      end else begin
         r_addr_rdy <= 1'b0;
         r_slv_resp <= 1'b0;
         r_strobe   <= 1'b0;
         if (r_sig_cnt != 2'd0) r_sig_cnt <= r_sig_cnt - 1'b1;
         if (!m1_tx && !r_m1) r_pend_m1 <= 1'b1;
         if (!m2_tx && !r_m2) r_pend_m2 <= 1'b1;

         case (r_state)
            S_IDLE: begin
`ifdef SPLIT_EN
               if (r_split_vld && !w_split_tx) begin
                  r_m1        <= !r_split_m;
                  r_m2        <= r_split_m;
                  r_addr      <= r_split_addr;
                  r_split_vld <= 1'b0;
                  r_slv_ready <= 1'b1;
                  r_sig_cnt   <= 2'd1;
                  r_sig_m     <= r_split_m;
                  r_cnt       <= '0;
                  r_state     <= S_DATA;
               end else
`endif
               if (r_pend_m1) begin
                  r_m1      <= 1'b1;
                  r_pend_m1 <= 1'b0;
                  r_sig_cnt <= 2'd1;
                  r_sig_m   <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_ADDR;
               end else if (r_pend_m2) begin
                  r_m2      <= 1'b1;
                  r_pend_m2 <= 1'b0;
                  r_sig_cnt <= 2'd1;
                  r_sig_m   <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (r_cnt == '0) begin
                  r_addr_msb <= w_gnt_tx;
                  r_cnt      <= CW'(1);
               end else begin
                  r_addr     <= {r_addr_msb, w_gnt_tx};
                  r_addr_rdy <= 1'b1;
                  r_state    <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (w_bad_addr) begin
                  r_sig_cnt <= 2'd2;
                  r_sig_m   <= r_m2;
                  r_m1      <= 1'b0;
                  r_m2      <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_strobe <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_WAIT_RDY;
               end
            end
            S_WAIT_RDY: begin
               if (!w_sel_tx) begin
                  r_slv_ready <= 1'b1;
                  r_sig_cnt   <= 2'd1;
                  r_sig_m     <= r_m2;
                  r_cnt       <= '0;
                  r_state     <= S_DATA;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
`ifdef SPLIT_EN
                  if (!r_split_vld) begin
                     r_sig_cnt    <= 2'd3;
                     r_split_vld  <= 1'b1;
                     r_split_m    <= r_m2;
                     r_split_addr <= r_addr;
                  end else begin
                     r_sig_cnt <= 2'd2;
                  end
`else
                  r_sig_cnt <= 2'd2;
`endif
                  r_sig_m     <= r_m2;
                  r_m1        <= 1'b0;
                  r_m2        <= 1'b0;
                  r_slv_ready <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == CW'(FRAME_LEN - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (!w_sel_tx) begin
                  r_slv_resp  <= 1'b1;
                  r_m1        <= 1'b0;
                  r_m2        <= 1'b0;
                  r_slv_ready <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_sig_cnt   <= 2'd2;
                  r_sig_m     <= r_m2;
                  r_m1        <= 1'b0;
                  r_m2        <= 1'b0;
                  r_slv_ready <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_decoder.sv
// Scoreboard bench for bus_arbiter_decoder: drives master/slave serial traffic on negedges
// and compares arbiter outputs; the split scenario is included when SPLIT_EN is defined.
module tb_bus_arbiter_decoder;

   localparam int FRAME_LEN = 10;
   localparam int TIMEOUT   = 16;
`ifdef SPLIT_EN
   localparam int TO_LOWS   = 3;
`else
   localparam int TO_LOWS   = 2;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       m1_tx = 1'b1, m2_tx = 1'b1;
   logic       s1_tx = 1'b1, s2_tx = 1'b1, s3_tx = 1'b1;
   logic       m1_rx, m2_rx, s1_rx, s2_rx, s3_rx;
   logic       m1, m2;
   logic [1:0] addr;
   logic       addr_rdy, slv_ready, slv_responded;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   bus_arbiter_decoder #(.FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .m1_tx(m1_tx), .m2_tx(m2_tx), .m1_rx(m1_rx), .m2_rx(m2_rx),
      .s1_tx(s1_tx), .s2_tx(s2_tx), .s3_tx(s3_tx),
      .s1_rx(s1_rx), .s2_rx(s2_rx), .s3_rx(s3_rx),
      .m1(m1), .m2(m2), .addr(addr), .addr_rdy(addr_rdy),
      .slv_ready(slv_ready), .slv_responded(slv_responded)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic get_gnt(input int mi);
      return (mi == 1) ? m1 : m2;
   endfunction

   function automatic logic get_mrx(input int mi);
      return (mi == 1) ? m1_rx : m2_rx;
   endfunction

   function automatic logic get_srx(input int k);
      case (k)
         1:       return s1_rx;
         2:       return s2_rx;
         default: return s3_rx;
      endcase
   endfunction

   function automatic logic [2:0] one_low(input int k);
      logic [2:0] e;
      e = 3'b111;
      e[k-1] = 1'b0;
      return e;
   endfunction

   task automatic set_mtx(input int mi, input logic v);
      if (mi == 1) m1_tx = v;
      else         m2_tx = v;
   endtask

   task automatic set_stx(input int k, input logic v);
      case (k)
         1:       s1_tx = v;
         2:       s2_tx = v;
         default: s3_tx = v;
      endcase
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_ctl"}, {m1, m2, addr, addr_rdy, slv_ready, slv_responded}, 32'd0);
      check_val({tag, "_rx"}, {m1_rx, m2_rx, s1_rx, s2_rx, s3_rx}, 32'h1f);
   endtask

   task automatic request(input int mi);
      step(); set_mtx(mi, 1'b0);
      step(); set_mtx(mi, 1'b1);
   endtask

   // Starts on the negedge where the grant/ACK becomes visible.
   task automatic addr_phase(input int mi, input logic [1:0] a);
      step(); set_mtx(mi, a[1]); settle();
      check_val("grant", get_gnt(mi), 1);
      check_val("other_grant", get_gnt(3 - mi), 0);
      check_val("grant_ack", get_mrx(mi), 0);
      step(); set_mtx(mi, a[0]);
      sb_push("addr", 32'(a));
      sb_push("addr_rdy", 1);
      settle();
      check_val("ack_end", get_mrx(mi), 1);
      step(); set_mtx(mi, 1'b1); settle();
      sb_pop(32'(addr));
      sb_pop(32'(addr_rdy));
   endtask

   task automatic select_ready(input int mi, input int a, input int d);
      for (int i = 0; i <= d; i++) begin
         step(); set_stx(a, (i == d) ? 1'b0 : 1'b1); settle();
         if (i == 0) begin
            check_val("select_strobe", {s3_rx, s2_rx, s1_rx}, 32'(one_low(a)));
            check_val("addr_rdy_pulse_end", addr_rdy, 0);
         end
         check_val("wait_rdy_level", slv_ready, 0);
         check_val("wait_grant", get_gnt(mi), 1);
      end
   endtask

   task automatic data_phase(input int mi, input int a, input int n);
      logic bm, bs;
      for (int i = 0; i < n; i++) begin
         step();
         bm = 1'($urandom_range(0, 1));
         bs = 1'($urandom_range(0, 1));
         set_mtx(mi, bm);
         set_stx(a, bs);
         sb_push("route_m2s", 32'(bm));
         sb_push("route_s2m", (i == 0) ? 32'd0 : 32'(bs));
         settle();
         sb_pop(32'(get_srx(a)));
         sb_pop(32'(get_mrx(mi)));
         check_val("idle_other_m_rx", get_mrx(3 - mi), 1);
         if (i == 0) begin
            check_val("slv_ready", slv_ready, 1);
            check_val("data_grant", get_gnt(mi), 1);
         end
      end
   endtask

   task automatic resp_phase(input int mi, input int a, input int d);
      for (int i = 0; i <= d; i++) begin
         step(); set_mtx(mi, 1'b1); set_stx(a, (i == d) ? 1'b0 : 1'b1); settle();
         if (i == 0) begin
            check_val("frame_closed_s_rx", get_srx(a), 1);
            check_val("frame_closed_m_rx", get_mrx(mi), 1);
         end
      end
      step(); set_stx(a, 1'b1); settle();
      check_val("slv_responded", slv_responded, 1);
      check_val("release_grant", {m1, m2}, 0);
      check_val("release_ready", slv_ready, 0);
   endtask

   task automatic expect_lows(input int mi, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         step(); settle();
         check_val({tag, "_low"}, get_mrx(mi), 0);
         check_val({tag, "_released"}, {m1, m2, slv_ready}, 0);
         if (i == 0) check_val({tag, "_no_strobe"}, {s1_rx, s2_rx, s3_rx}, 32'h7);
      end
      step(); settle();
      check_val({tag, "_end"}, get_mrx(mi), 1);
   endtask

   task automatic wait_timeout(input int mi, input int a);
      step(); settle();
      check_val("to_strobe", {s3_rx, s2_rx, s1_rx}, 32'(one_low(a)));
      for (int i = 1; i < TIMEOUT; i++) begin
         step(); settle();
         check_val("to_grant_held", get_gnt(mi), 1);
         check_val("to_not_ready", slv_ready, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      step(); step(); settle();
      check_idle_outputs("reset");
      step(); rstn = 1'b0;

      // m1 -> s1, ready after a few cycles, full frame, response
      request(1);
      addr_phase(1, 2'b01);
      select_ready(1, 1, 2);
      data_phase(1, 1, FRAME_LEN);
      resp_phase(1, 1, 0);
      step(); settle();
      check_val("responded_pulse_end", slv_responded, 0);
      $display("txn: m1 -> s1 frame done");

      // Simultaneous requests: m1 first, then m2 without resending
      step(); m1_tx = 1'b0; m2_tx = 1'b0;
      step(); m1_tx = 1'b1; m2_tx = 1'b1;
      addr_phase(1, 2'b01);
      select_ready(1, 1, 0);
      data_phase(1, 1, FRAME_LEN);
      resp_phase(1, 1, 0);
      addr_phase(2, 2'b11);
      select_ready(2, 3, 1);
      data_phase(2, 3, FRAME_LEN);
      resp_phase(2, 3, 1);
      $display("txn: m1 then pending m2 -> s3 done");

      // Invalid address
      request(1);
      addr_phase(1, 2'b00);
      expect_lows(1, 2, "nack_addr0");
      $display("txn: addr 00 nacked");

      // Slave never ready
      request(1);
      addr_phase(1, 2'b10);
      wait_timeout(1, 2);
      expect_lows(1, TO_LOWS, "rdy_timeout");
      $display("txn: s2 ready timeout");

      // Reset in the middle of the data phase
      request(1);
      addr_phase(1, 2'b01);
      select_ready(1, 1, 1);
      data_phase(1, 1, 3);
      step(); rstn = 1'b1; m1_tx = 1'b1; s1_tx = 1'b1;
      step(); rstn = 1'b0; settle();
      check_idle_outputs("mid_reset");
      step(); settle();
      check_val("post_reset_idle", {m1, m2}, 0);
      $display("txn: reset mid-data");

`ifdef SPLIT_EN
      // Split: m1 to busy s1, m2 uses bus, s1 later recalls m1
      request(1);
      addr_phase(1, 2'b01);
      wait_timeout(1, 1);
      expect_lows(1, 3, "split");
      request(2);
      addr_phase(2, 2'b10);
      select_ready(2, 2, 0);
      data_phase(2, 2, FRAME_LEN);
      resp_phase(2, 2, 0);
      step(); set_stx(1, 1'b0);
      data_phase(1, 1, FRAME_LEN);
      check_val("split_addr", addr, 2'b01);
      resp_phase(1, 1, 0);
      $display("txn: split m1 resumed after m2");
`endif

      check_val("queue_drained", 32'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
